// File: rtl/snr_estimator_if.sv
// Sample stream in, SNR result out: the link between the demodulator,
// snr_estimator and the APB register block.
interface snr_estimator_if #(
    parameter int DW = 12
) ();
    logic signed [DW-1:0] sample_i;
    logic signed [DW-1:0] sample_q;
    logic                 sample_valid;
    logic [16:0]          SNR;
    logic                 snr_valid;
    logic                 snr_sat;

    modport master (
        output sample_i, sample_q, sample_valid,
        input  SNR, snr_valid, snr_sat
    );

    modport slave (
        input  sample_i, sample_q, sample_valid,
        output SNR, snr_valid, snr_sat
    );
endinterface

// File: rtl/snr_estimator.sv
// Windowed I/Q SNR estimator: S/N as unsigned Q9.8 via a restoring divider.
// Define SNR_AVG_EN to smooth SNR with a 1/4-weight exponential average.
module snr_estimator #(
    parameter int DW       = 12,
    parameter int WIN_LOG2 = 10
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic enable,
    snr_estimator_if.slave bus
);

    localparam int MW = DW - 1;
    localparam int AW = MW + WIN_LOG2;
    localparam int PW = 2 * DW + WIN_LOG2;
    localparam int SW = 2 * DW - 1;
    localparam int NW = 2 * DW;
    localparam int CW = NW + 9;
    localparam int QW = 17;

    typedef enum logic [1:0] {IDLE, CALC, DIV, DONE} state_t;

    state_t         state, state_nxt;
    logic [AW-1:0]  sum_abs_i, sum_abs_q, nxt_abs_i, nxt_abs_q;
    logic [PW-1:0]  sum_pwr, nxt_pwr;
    logic [WIN_LOG2-1:0] cnt;
    logic [MW-1:0]  abs_i, abs_q, snap_mi, snap_mq;
    logic [NW-1:0]  snap_p;
    logic           snap_pend;
    logic signed [2*DW-1:0] ext_i, ext_q;
    logic [2*DW-1:0] pwr;
    logic           accept, last;
    logic [SW-1:0]  s_val;
    logic [NW-1:0]  n_val;
    logic           sat_cond;
    logic [QW-1:0]  result;
    logic           res_sat;
    logic [NW-1:0]  rem, divisor, rem_sub;
    logic [QW-1:0]  dlo;
    logic [NW:0]    trial;
    logic           ge;
    logic [4:0]     div_cnt;

    // The most negative code has no positive twin, so it clamps to max.
    function automatic logic [MW-1:0] mag(input logic signed [DW-1:0] x);
        if (x == {1'b1, {(DW-1){1'b0}}})
            return {MW{1'b1}};
        else if (x[DW-1])
            return MW'(-x);
        else
            return MW'(x);
    endfunction

    assign abs_i     = mag(bus.sample_i);
    assign abs_q     = mag(bus.sample_q);
    assign ext_i     = {{DW{bus.sample_i[DW-1]}}, bus.sample_i};
    assign ext_q     = {{DW{bus.sample_q[DW-1]}}, bus.sample_q};
    assign pwr       = $unsigned(ext_i * ext_i) + $unsigned(ext_q * ext_q);
    assign nxt_abs_i = sum_abs_i + AW'(abs_i);
    assign nxt_abs_q = sum_abs_q + AW'(abs_q);
    assign nxt_pwr   = sum_pwr + PW'(pwr);
    assign accept    = enable & bus.sample_valid;
    assign last      = accept & (cnt == '1);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            sum_abs_i <= '0;
            sum_abs_q <= '0;
            sum_pwr   <= '0;
            cnt       <= '0;
            snap_mi   <= '0;
            snap_mq   <= '0;
            snap_p    <= '0;
            snap_pend <= 1'b0;
        end else if (!enable) begin
            sum_abs_i <= '0;
            sum_abs_q <= '0;
            sum_pwr   <= '0;
            cnt       <= '0;
            snap_pend <= 1'b0;
        end else begin
            if (accept) begin
                cnt <= cnt + 1'b1;
                if (last) begin
                    sum_abs_i <= '0;
                    sum_abs_q <= '0;
                    sum_pwr   <= '0;
                    snap_mi   <= nxt_abs_i[AW-1:WIN_LOG2];
                    snap_mq   <= nxt_abs_q[AW-1:WIN_LOG2];
                    snap_p    <= nxt_pwr[PW-1:WIN_LOG2];
                end else begin
                    sum_abs_i <= nxt_abs_i;
                    sum_abs_q <= nxt_abs_q;
                    sum_pwr   <= nxt_pwr;
                end
            end
            if (last)
                snap_pend <= 1'b1;
            else if (state == IDLE)
                snap_pend <= 1'b0;
        end
    end

    assign s_val    = SW'(snap_mi) * SW'(snap_mi) + SW'(snap_mq) * SW'(snap_mq);
    assign n_val    = (snap_p > NW'(s_val)) ? snap_p - NW'(s_val) : '0;
    assign sat_cond = (n_val == '0) || (CW'(s_val) >= {n_val, 9'b0});

    // Partial remainder stays below the divisor, so one extra bit holds the trial.
    assign trial   = {rem, dlo[QW-1]};
    assign ge      = trial >= {1'b0, divisor};
    assign rem_sub = trial[NW-1:0] - divisor;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            state <= IDLE;
        else if (!enable)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (snap_pend) state_nxt = CALC;
            CALC:    state_nxt = ((s_val == '0) || sat_cond) ? DONE : DIV;
            DIV:     if (div_cnt == 5'd16) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            result  <= '0;
            res_sat <= 1'b0;
            rem     <= '0;
            divisor <= '0;
            dlo     <= '0;
            div_cnt <= '0;
        end else begin
            case (state)
                CALC: begin
                    div_cnt <= '0;
                    if (s_val == '0) begin
                        result  <= '0;
                        res_sat <= 1'b0;
                    end else if (sat_cond) begin
                        result  <= '1;
                        res_sat <= 1'b1;
                    end else begin
                        result  <= '0;
                        res_sat <= 1'b0;
                        rem     <= NW'(s_val >> 9);
                        dlo     <= {s_val[8:0], 8'b0};
                        divisor <= n_val;
                    end
                end
                DIV: begin
                    rem     <= ge ? rem_sub : trial[NW-1:0];
                    dlo     <= dlo << 1;
                    result  <= {result[QW-2:0], ge};
                    div_cnt <= div_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SNR_AVG_EN
    logic        avg_first;
    logic signed [17:0] avg_diff;
    assign avg_diff = $signed({1'b0, result}) - $signed({1'b0, bus.SNR});
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            bus.SNR       <= '0;
            bus.snr_valid <= 1'b0;
            bus.snr_sat   <= 1'b0;
`ifdef SNR_AVG_EN
            avg_first     <= 1'b1;
`endif
        end else begin
            bus.snr_valid <= enable && (state == DONE);
            if (enable && (state == DONE)) begin
                bus.snr_sat <= res_sat;
`ifdef SNR_AVG_EN
                bus.SNR     <= avg_first ? result : bus.SNR + 17'(avg_diff >>> 2);
                avg_first   <= 1'b0;
`else
                bus.SNR     <= result;
`endif
            end
`ifdef SNR_AVG_EN
            else if (!enable) begin
                avg_first <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_snr_estimator.sv
// Directed bench for snr_estimator: arithmetic window model checked every
// cycle, plus literal expectations for the worked examples.
module tb_snr_estimator;

    localparam int DW       = 12;
    localparam int WIN_LOG2 = 10;
    localparam int WIN      = 1 << WIN_LOG2;

    logic PCLK    = 1'b0;
    logic PRESETn = 1'b0;
    logic enable  = 1'b0;

    snr_estimator_if #(.DW(DW)) bus ();

    snr_estimator #(.DW(DW), .WIN_LOG2(WIN_LOG2)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .enable  (enable),
        .bus     (bus)
    );

    always #5 PCLK = ~PCLK;

    int total = 0;
    int bad   = 0;
    int mcyc  = 0;
    int last_cyc = 0;

    longint m_abs_i = 0, m_abs_q = 0, m_pwr = 0;
    int     m_cnt = 0;
    longint mi, mq, mp, ms, mn, mr;
    int     xi, xq, mlat;
    bit     msat;
    bit     pend = 1'b0;
    int     due = 0;
    logic [16:0] pend_snr = '0;
    bit     pend_sat = 1'b0;
    logic [16:0] exp_snr = '0;
    bit     exp_sat = 1'b0;
    bit     exp_valid = 1'b0;

    function automatic longint magnitude(input int x);
        if (x == -(1 << (DW - 1))) return longint'((1 << (DW - 1)) - 1);
        return (x < 0) ? longint'(-x) : longint'(x);
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Window model: means by integer division, ratio by integer divide.
    always begin
        @(posedge PCLK or negedge PRESETn);
        if (!PRESETn) begin
            m_abs_i = 0; m_abs_q = 0; m_pwr = 0; m_cnt = 0;
            pend = 1'b0; exp_snr = '0; exp_sat = 1'b0; exp_valid = 1'b0;
        end else begin
            mcyc++;
            exp_valid = 1'b0;
            if (!enable) begin
                m_abs_i = 0; m_abs_q = 0; m_pwr = 0; m_cnt = 0;
                pend = 1'b0;
            end else begin
                if (pend && mcyc == due) begin
                    exp_valid = 1'b1;
                    exp_snr   = pend_snr;
                    exp_sat   = pend_sat;
                    pend      = 1'b0;
                end
                if (bus.sample_valid) begin
                    xi = int'(bus.sample_i);
                    xq = int'(bus.sample_q);
                    m_abs_i += magnitude(xi);
                    m_abs_q += magnitude(xq);
                    m_pwr   += longint'(xi * xi + xq * xq);
                    m_cnt++;
                    if (m_cnt == WIN) begin
                        mi = m_abs_i / WIN;
                        mq = m_abs_q / WIN;
                        mp = m_pwr / WIN;
                        ms = mi * mi + mq * mq;
                        mn = (mp > ms) ? mp - ms : 0;
                        if (ms == 0) begin
                            mr = 0; msat = 1'b0; mlat = 3;
                        end else if (mn == 0 || ms >= mn * 512) begin
                            mr = 131071; msat = 1'b1; mlat = 3;
                        end else begin
                            mr = (ms * 256) / mn; msat = 1'b0; mlat = 20;
                        end
                        pend_snr = 17'(mr);
                        pend_sat = msat;
                        pend     = 1'b1;
                        due      = mcyc + mlat;
                        m_abs_i = 0; m_abs_q = 0; m_pwr = 0; m_cnt = 0;
                    end
                end
            end
        end
    end

    always begin
        @(posedge PCLK);
        #1;
        checkOutput("cyc_snr_valid", bus.snr_valid, exp_valid);
        checkOutput("cyc_SNR", bus.SNR, exp_snr);
        checkOutput("cyc_snr_sat", bus.snr_sat, exp_sat);
    end

    // Called and returns 2 time units after a rising edge.
    task automatic applyStimulus(input int n, input int ia, input int ib, input int qv, input int gap_pct);
        for (int k = 0; k < n; k++) begin
            if (gap_pct > 0) begin
                while ($urandom_range(99) < gap_pct) begin
                    bus.sample_valid = 1'b0;
                    @(posedge PCLK);
                    #2;
                end
            end
            bus.sample_i     = DW'((k % 2 == 0) ? ia : ib);
            bus.sample_q     = DW'(qv);
            bus.sample_valid = 1'b1;
            @(posedge PCLK);
            #2;
        end
        bus.sample_valid = 1'b0;
        last_cyc = mcyc;
    endtask

    task automatic waitResult(input string name, input int exp_lat, input logic [16:0] exp_val, input bit exp_s);
        int lat;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge PCLK);
            #1;
            if (bus.snr_valid) begin
                lat = mcyc - last_cyc;
                break;
            end
        end
        #1;
        checkOutput({name, "_latency"}, lat, exp_lat);
        checkOutput({name, "_SNR"}, bus.SNR, exp_val);
        checkOutput({name, "_sat"}, bus.snr_sat, exp_s);
    endtask

    initial begin
        int pulses;
        bus.sample_i     = '0;
        bus.sample_q     = '0;
        bus.sample_valid = 1'b0;
        repeat (3) @(posedge PCLK);
        #2;
        checkOutput("reset_SNR", bus.SNR, 0);
        checkOutput("reset_valid", bus.snr_valid, 0);
        checkOutput("reset_sat", bus.snr_sat, 0);
        PRESETn = 1'b1;
        enable  = 1'b1;
        @(posedge PCLK);
        #2;

        $display("[TB] alternating 1000/-600: divide path");
        applyStimulus(WIN, 1000, -600, 0, 0);
        waitResult("alt_div", 20, 17'h01000, 1'b0);

        $display("[TB] alternating 1000/999: ratio too large");
        applyStimulus(WIN, 1000, 999, 0, 0);
        waitResult("near_sat", 3, 17'h1FFFF, 1'b1);

        $display("[TB] all-zero window");
        applyStimulus(WIN, 0, 0, 0, 0);
        waitResult("zero", 3, 17'h00000, 1'b0);

        $display("[TB] constant 500/500: no noise");
        applyStimulus(WIN, 500, 500, 500, 0);
        waitResult("no_noise", 3, 17'h1FFFF, 1'b1);

        $display("[TB] constant -2048: clamped magnitude");
        applyStimulus(WIN, -2048, -2048, 0, 0);
        waitResult("neg_full", 3, 17'h1FFFF, 1'b1);

        $display("[TB] enable dropped mid-window");
        applyStimulus(600, 1000, -600, 0, 0);
        enable = 1'b0;
        repeat (5) begin
            @(posedge PCLK);
            #2;
        end
        checkOutput("hold_SNR", bus.SNR, 17'h1FFFF);
        checkOutput("hold_sat", bus.snr_sat, 1);
        enable = 1'b1;
        applyStimulus(WIN, 1000, -600, 0, 0);
        waitResult("restart", 20, 17'h01000, 1'b0);

        $display("[TB] reset during divide");
        applyStimulus(WIN, 1000, -600, 0, 0);
        repeat (10) begin
            @(posedge PCLK);
            #2;
        end
        PRESETn = 1'b0;
        #1;
        checkOutput("async_rst_SNR", bus.SNR, 0);
        checkOutput("async_rst_valid", bus.snr_valid, 0);
        checkOutput("async_rst_sat", bus.snr_sat, 0);
        repeat (3) @(posedge PCLK);
        #2;
        PRESETn = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge PCLK);
            #2;
            if (bus.snr_valid) pulses++;
        end
        checkOutput("no_pulse_after_reset", pulses, 0);

        $display("[TB] alternating 1000/-600 with valid gaps");
        applyStimulus(WIN, 1000, -600, 0, 30);
        waitResult("gaps", 20, 17'h01000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
